fxp_arith_unit: RTL and testbench



---
 rtl/fxp_arith_unit_pkg.sv | 15 +
 rtl/fxp_isqrt_step.sv | 25 ++
 rtl/fxp_arith_unit.sv | 172 +++++++++++++++++
 tb/tb_fxp_arith_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fxp_arith_unit_pkg.sv
// Shared opcode constants and FSM state encoding for the fixed-point arithmetic unit.
package fxp_arith_unit_pkg;

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fxp_isqrt_step.sv
// One combinational iteration of the restoring digit-by-digit square root:
// brings down two radicand bits and decides the next root bit.
module fxp_isqrt_step #(
    parameter int RW = 24,
    parameter int QW = 21
) (
    input  logic [RW-1:0] rem_i,
    input  logic [QW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [RW-1:0] rem_o,
    output logic [QW-1:0] root_o
);

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    logic          ge;

    // The remainder never exceeds 2*root, so its top two bits are always zero here.
    assign rem_sh = {rem_i[RW-3:0], bits_i};
    assign trial  = RW'({root_i, 2'b01});
    assign ge     = (rem_sh >= trial);
    assign rem_o  = ge ? (rem_sh - trial) : rem_sh;
    assign root_o = (root_i << 1) | QW'(ge);

endmodule

// File: rtl/fxp_arith_unit.sv
// Handshaked unsigned Q(WIDTH-FBITS).FBITS add/sub/mul/sqrt unit.
// Define FXP_SAT_EN to saturate results on overflow instead of wrapping.
module fxp_arith_unit
    import fxp_arith_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             done,
    output logic             busy
);

    localparam int M  = WIDTH + FBITS;
    localparam int N  = M / 2;
    localparam int RW = N + 3;
    localparam int CW = $clog2(WIDTH + 1);

`ifdef FXP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [M-1:0]       rad_q, rad_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [N-1:0]       root_q, root_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] acc_nxt, prod_sh;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;
    logic [RW-1:0]      rem_nxt;
    logic [N-1:0]       root_nxt;

    fxp_isqrt_step #(.RW(RW), .QW(N)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[M-1 -: 2]),
        .rem_o  (rem_nxt),
        .root_o (root_nxt)
    );

    assign sum     = {1'b0, operand_1} + {1'b0, operand_2};
    assign diff    = {1'b0, operand_1} - {1'b0, operand_2};
    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Shifts rather than part-selects keep FBITS=0 and FBITS=WIDTH legal.
    assign prod_sh = acc_nxt >> FBITS;
    assign mul_res = prod_sh[WIDTH-1:0];
    assign mul_ovf = |(acc_nxt >> M);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = operation;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, operand_1};
                    mplier_d = operand_2;
                    rad_d    = M'(operand_1) << FBITS;
                    rem_d    = '0;
                    root_d   = '0;
                    case (operation)
                        FPU_ADD: begin
                            ovf_d    = sum[WIDTH];
                            result_d = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                            state_d  = DONE;
                        end
                        FPU_SUB: begin
                            ovf_d    = diff[WIDTH];
                            result_d = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
                            state_d  = DONE;
                        end
                        FPU_MUL: begin
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = EXEC;
                        end
                        default: begin
                            cnt_d   = CW'(N - 1);
                            state_d = EXEC;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (op_q == FPU_MUL) begin
                    acc_d    = acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    rem_d  = rem_nxt;
                    root_d = root_nxt;
                    rad_d  = rad_q << 2;
                end
                cnt_d = cnt_q - 1'b1;
                // The last iteration's combinational value is the final answer.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (op_q == FPU_MUL) begin
                        ovf_d    = mul_ovf;
                        result_d = (SAT && mul_ovf) ? '1 : mul_res;
                    end else begin
                        ovf_d    = 1'b0;
                        result_d = WIDTH'(root_nxt);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Randomized self-checking bench for fxp_arith_unit (WIDTH=32, FBITS=10) against an arithmetic model.
module tb_fxp_arith_unit;
    import fxp_arith_unit_pkg::*;

    localparam int W = 32;
    localparam int F = 10;
    localparam int N = (W + F) / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   operation = 2'd0;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic [W-1:0] result;
    logic         overflow;
    logic         done;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    fxp_arith_unit #(.WIDTH(W), .FBITS(F)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .result    (result),
        .overflow  (overflow),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued fixed-point meaning.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o, output int lat);
        logic [63:0] x, p, rt, t;
        bit sat;
`ifdef FXP_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        case (op)
            FPU_ADD: begin
                x = 64'(a) + 64'(b);
                o = (x > 64'hFFFF_FFFF);
                r = (sat && o) ? '1 : x[W-1:0];
                lat = 1;
            end
            FPU_SUB: begin
                o = (a < b);
                r = (sat && o) ? '0 : a - b;
                lat = 1;
            end
            FPU_MUL: begin
                p = 64'(a) * 64'(b);
                x = p >> F;
                o = ((p >> (W + F)) != 0);
                r = (sat && o) ? '1 : x[W-1:0];
                lat = W + 1;
            end
            default: begin
                x  = 64'(a) << F;
                rt = 0;
                for (int k = N - 1; k >= 0; k--) begin
                    t = rt | (64'd1 << k);
                    if (t * t <= x) rt = t;
                end
                o = 1'b0;
                r = rt[W-1:0];
                lat = N + 1;
            end
        endcase
    endfunction

    // Issues one operation, checks latency/result/flag, and pokes start while busy.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke_mid);
        logic [W-1:0] er;
        logic         eo;
        int           elat, lat;
        model(op, a, b, er, eo, elat);
        @(negedge clk);
        start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; operation = 2'($urandom); operand_1 = $urandom; operand_2 = $urandom;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_after_accept", 64'(busy), 64'd1);
            if (poke_mid && k == 4) start = 1'b1;
            if (poke_mid && k == 5) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("result", 64'(result), 64'(er));
        chk("overflow", 64'(overflow), 64'(eo));
        chk("busy_in_done", 64'(busy), 64'd1);
        start = 1'b1;
        @(negedge clk);
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("result_held", 64'(result), 64'(er));
        start = 1'b0;
    endtask

    initial begin
        int ndone;
        logic [W-1:0] a, b;
        repeat (2) @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        do_op(FPU_ADD,  32'h600, 32'h900, 1'b0);
        do_op(FPU_MUL,  32'h600, 32'h600, 1'b1);
        do_op(FPU_SQRT, 32'h900, 32'h0,   1'b1);
        do_op(FPU_SQRT, 32'h0,   32'h0,   1'b0);
        do_op(FPU_SUB,  32'h600, 32'h900, 1'b0);
        do_op(FPU_ADD,  32'hFFFF_FFFF, 32'h1, 1'b0);
        do_op(FPU_MUL,  32'h10_0000, 32'h10_0000, 1'b0);
        do_op(FPU_MUL,  32'h0, 32'hFFFF_FFFF, 1'b0);
        do_op(FPU_SQRT, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_op(FPU_SUB,  32'h1234, 32'h1234, 1'b0);

        // Reset mid-multiply, with a start presented in the reset cycle.
        @(negedge clk);
        start = 1'b1; operation = FPU_MUL; operand_1 = 32'h600; operand_2 = 32'h600;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b1; operation = FPU_ADD; operand_1 = 32'h1; operand_2 = 32'h2;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);
        do_op(FPU_ADD, 32'h600, 32'h900, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = a >> $urandom_range(0, 31);
                1: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(2'($urandom), a, b, i[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
